// File: rtl/mcpu_pkg.sv
// Shared constants and types for the 6-bit MCPU and its program memory.
// Opcode encodings are provided for benches and program loaders.
package mcpu_pkg;
    localparam int WIDTH = 6;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        NOR = 2'b00,
        ADD = 2'b01,
        STA = 2'b10,
        JCC = 2'b11
    } opcode_t;

    // Packs an opcode and a 4-bit operand address into one instruction word.
    function automatic logic [WIDTH-1:0] make_instr(input opcode_t op, input logic [AW-1:0] addr);
        return {op, addr};
    endfunction
endpackage

// File: rtl/mcpu_progmem_if.sv
// Core bus and loader port of the MCPU program memory.
// master = core/loader side, slave = memory side.
interface mcpu_progmem_if;
    import mcpu_pkg::*;

    logic [WIDTH-1:0] cpu_bus;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_datain;
    logic             cpu_rst_n;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_ready;
    logic             ld_start;
    logic             ld_done;

    modport master (
        output cpu_bus, cpu_we, ld_valid, ld_data, ld_start,
        input  cpu_datain, cpu_rst_n, ld_ready, ld_done
    );

    modport slave (
        input  cpu_bus, cpu_we, ld_valid, ld_data, ld_start,
        output cpu_datain, cpu_rst_n, ld_ready, ld_done
    );
endinterface

// File: rtl/mcpu_ram16x6.sv
// 16 x 6 storage array: one posedge write port, asynchronous read port.
// Contents are deliberately not reset.
module mcpu_ram16x6
    import mcpu_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read-during-write yields the old word since the write lands at the edge.
    assign rdata = mem_reg[raddr];
endmodule

// File: rtl/mcpu_progmem.sv
// Unified program/data memory for the MCPU: demultiplexes the core bus,
// serves reads/stores, and loads a program over valid/ready while holding the core in reset.
module mcpu_progmem
    import mcpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mcpu_progmem_if.slave bus
);
    logic [AW-1:0]    addr_reg;
    logic [AW-1:0]    ld_ptr_reg;
    state_t           state_reg;
    logic             ld_ready_reg;
    logic             ld_done_reg;
    logic             cpu_rst_n_reg;
    logic             ld_fire;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             unused_bus_bits;

    // The bus carries {00,adreg} while clk is high; capture it on the falling edge.
    always_ff @(negedge clk) begin
        if (rst) begin
            addr_reg <= '0;
        end else begin
            addr_reg <= bus.cpu_bus[AW-1:0];
        end
    end

    assign unused_bus_bits = ^bus.cpu_bus[WIDTH-1:AW];

    assign ld_fire   = (state_reg == LOAD) && bus.ld_valid && ld_ready_reg;
    assign ram_we    = !rst && ((state_reg == LOAD) ? ld_fire : !bus.cpu_we);
    assign ram_waddr = (state_reg == LOAD) ? ld_ptr_reg : addr_reg;
    assign ram_wdata = (state_reg == LOAD) ? bus.ld_data : bus.cpu_bus;

    mcpu_ram16x6 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (addr_reg),
        .rdata (bus.cpu_datain)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LOAD;
            ld_ptr_reg    <= '0;
            ld_ready_reg  <= 1'b1;
            ld_done_reg   <= 1'b0;
            cpu_rst_n_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (ld_fire) begin
                        ld_ptr_reg <= ld_ptr_reg + 1'b1;
                        if (&ld_ptr_reg) begin
                            state_reg     <= RUN;
                            ld_ready_reg  <= 1'b0;
                            ld_done_reg   <= 1'b1;
                            cpu_rst_n_reg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.ld_start) begin
                        state_reg     <= LOAD;
                        ld_ptr_reg    <= '0;
                        ld_ready_reg  <= 1'b1;
                        ld_done_reg   <= 1'b0;
                        cpu_rst_n_reg <= 1'b0;
                    end
                end
                default: state_reg <= LOAD;
            endcase
        end
    end

    assign bus.ld_ready  = ld_ready_reg;
    assign bus.ld_done   = ld_done_reg;
    assign bus.cpu_rst_n = cpu_rst_n_reg;
endmodule

// File: tb/tb_mcpu_progmem.sv
// Directed bench for mcpu_progmem: load, read, store, stall, reset and reload scenarios.
module tb_mcpu_progmem;
    import mcpu_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [WIDTH-1:0] rd;

    mcpu_progmem_if bus_if();

    mcpu_progmem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
        $display("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // All tasks start and end 1 time unit after a posedge.
    task automatic load_word(input logic [WIDTH-1:0] d);
        bus_if.ld_valid = 1'b1;
        bus_if.ld_data  = d;
        @(posedge clk); #1;
        bus_if.ld_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cpu_access(input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                              input logic we_n, output logic [WIDTH-1:0] data);
        bus_if.cpu_bus = {2'b00, a};
        bus_if.cpu_we  = 1'b1;
        @(negedge clk); #1;
        data           = bus_if.cpu_datain;
        bus_if.cpu_bus = d;
        bus_if.cpu_we  = we_n;
        @(posedge clk); #1;
        bus_if.cpu_we  = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.cpu_bus  = '0;
        bus_if.cpu_we   = 1'b1;
        bus_if.ld_valid = 1'b0;
        bus_if.ld_data  = '0;
        bus_if.ld_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ld_ready", 8'(bus_if.ld_ready), 8'h1);
        chk("rst_ld_done", 8'(bus_if.ld_done), 8'h0);
        chk("rst_cpu_rst_n", 8'(bus_if.cpu_rst_n), 8'h0);
        chk("rst_ld_ptr", 8'(dut.ld_ptr_reg), 8'h0);

        // T1: 16 back-to-back words, value = address + 1
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                chk("t1_ready_before_last", 8'(bus_if.ld_ready), 8'h1);
                chk("t1_rst_n_before_last", 8'(bus_if.cpu_rst_n), 8'h0);
            end
            load_word(WIDTH'(i + 1));
        end
        chk("t1_ld_ready", 8'(bus_if.ld_ready), 8'h0);
        chk("t1_ld_done", 8'(bus_if.ld_done), 8'h1);
        chk("t1_cpu_rst_n", 8'(bus_if.cpu_rst_n), 8'h1);
        cpu_access(4'd15, 6'h00, 1'b1, rd);
        chk("t1_mem15", 8'(rd), 8'h10);
        cpu_access(4'd0, 6'h00, 1'b1, rd);
        chk("t1_mem0", 8'(rd), 8'h01);

        // T2: plain read
        cpu_access(4'd5, 6'h00, 1'b1, rd);
        chk("t2_mem5", 8'(rd), 8'h06);

        // T3: store 0x2A to addr 9 (upper bus bits during address phase ignored), then read back
        cpu_access(4'd9, 6'h2A, 1'b0, rd);
        chk("t3_old_word", 8'(rd), 8'h0A);
        bus_if.cpu_bus = 6'h39;
        @(negedge clk); #1;
        chk("t3_upper_bits_ignored", 8'(bus_if.cpu_datain), 8'h2A);
        @(posedge clk); #1;
        cpu_access(4'd9, 6'h00, 1'b1, rd);
        chk("t3_mem9", 8'(rd), 8'h2A);

        // T6: ld_start coincident with a store of 0x11 to addr 3
        bus_if.cpu_bus = 6'h03;
        @(negedge clk); #1;
        bus_if.cpu_bus  = 6'h11;
        bus_if.cpu_we   = 1'b0;
        bus_if.ld_start = 1'b1;
        @(posedge clk); #1;
        bus_if.cpu_we   = 1'b1;
        bus_if.ld_start = 1'b0;
        chk("t6_cpu_rst_n", 8'(bus_if.cpu_rst_n), 8'h0);
        chk("t6_ld_ptr", 8'(dut.ld_ptr_reg), 8'h0);
        chk("t6_ld_ready", 8'(bus_if.ld_ready), 8'h1);
        chk("t6_ld_done", 8'(bus_if.ld_done), 8'h0);
        cpu_access(4'd3, 6'h00, 1'b1, rd);
        chk("t6_mem3", 8'(rd), 8'h11);
        chk("t6_cpu_we_ignored_in_load", 8'(dut.ld_ptr_reg), 8'h0);

        // T4: 8 words, 3-cycle valid gap, then 8 more
        for (int i = 0; i < 8; i++) load_word(WIDTH'(8'h20 + i));
        chk("t4_ptr_after_8", 8'(dut.ld_ptr_reg), 8'h8);
        idle(2);
        cpu_access(4'd8, 6'h00, 1'b1, rd);
        chk("t4_mem8_untouched", 8'(rd), 8'h09);
        chk("t4_ptr_held", 8'(dut.ld_ptr_reg), 8'h8);
        chk("t4_not_done", 8'(bus_if.ld_done), 8'h0);
        for (int i = 8; i < 16; i++) begin
            if (i == 15) chk("t4_done_before_last", 8'(bus_if.ld_done), 8'h0);
            load_word(WIDTH'(8'h20 + i));
        end
        chk("t4_done", 8'(bus_if.ld_done), 8'h1);
        cpu_access(4'd3, 6'h00, 1'b1, rd);
        chk("t4_mem3", 8'(rd), 8'h23);
        cpu_access(4'd8, 6'h00, 1'b1, rd);
        chk("t4_mem8", 8'(rd), 8'h28);
        cpu_access(4'd9, 6'h00, 1'b1, rd);
        chk("t4_mem9", 8'(rd), 8'h29);

        // T5: reload, reset after 10 words, then 16 words of 0x3F
        bus_if.ld_start = 1'b1;
        @(posedge clk); #1;
        bus_if.ld_start = 1'b0;
        chk("t5_reload_rst_n", 8'(bus_if.cpu_rst_n), 8'h0);
        for (int i = 0; i < 10; i++) load_word(6'h01);
        chk("t5_ptr_10", 8'(dut.ld_ptr_reg), 8'hA);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t5_ptr_restart", 8'(dut.ld_ptr_reg), 8'h0);
        chk("t5_ready_after_rst", 8'(bus_if.ld_ready), 8'h1);
        for (int i = 0; i < 16; i++) load_word(6'h3F);
        chk("t5_done", 8'(bus_if.ld_done), 8'h1);
        for (int i = 0; i < 16; i++) begin
            cpu_access(AW'(i), 6'h00, 1'b1, rd);
            chk($sformatf("t5_mem%0d", i), 8'(rd), 8'h3F);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
